ram_multiport_sync: RTL and testbench

Parametrised, clocked successor to the combinational multi-read-port program RAM. It provides NUM_RD registered read ports, one write port, a sequenced clear engine and sticky halt-word detection. It sits between the parallel fetch/decode lanes and the loader. Lane i fetches through read port i; the loader or store path uses the write port.

---
 rtl/ram_multiport_sync.sv | 176 +++++++++++++++++
 tb/tb_ram_multiport_sync.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_multiport_sync.sv
// ram_multiport_sync: clocked multi-read-port program RAM.
//
// NUM_RD independent registered read ports (1-cycle latency, write-first on collision), one
// write port, a sequenced full-memory clear engine and sticky halt-word detection.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst_n       async active-low reset of control/output registers (memory is not reset)
//   rd_en       per-port read strobe
//   rd_addr     packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data     packed registered read data, port i at [i*DATA_W +: DATA_W]
//   rd_valid    per-port valid for rd_data
//   wr_en       write strobe
//   wr_addr     write address
//   wr_data     write data
//   wr_drop     one-cycle pulse: a write was discarded because a clear was in progress
//   clear_req   start a full-memory clear (level, sampled each cycle)
//   clear_busy  clear engine active
//   clear_done  one-cycle pulse at clear completion
//   halt        sticky: some valid read returned HALT_WORD
//   halt_port   sticky per-port halt flags
module ram_multiport_sync #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       NUM_RD    = 4,
  parameter logic [DATA_W-1:0] HALT_WORD = '1,
  parameter string             INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_drop,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic                       halt,
  output logic [NUM_RD-1:0]          halt_port
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         clr_cnt_q, clr_cnt_d;
  logic                      clear_done_q, clear_done_d;
  logic                      wr_drop_q, wr_drop_d;
  logic [NUM_RD*DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]         rd_valid_q, rd_valid_d;
  logic [NUM_RD-1:0]         halt_port_q, halt_port_d;

  logic [DATA_W-1:0]         mem [Depth];

  logic                      clear_start;
  logic                      clearing;
  logic                      wr_accept;
  logic [ADDR_W-1:0]         rd_addr_lane [NUM_RD];
  logic [DATA_W-1:0]         rd_word [NUM_RD];
  logic [NUM_RD-1:0]         halt_hit;

  // Memory is treated as logically zero from the request edge onward, so the request edge
  // itself already counts as "clearing" for reads and writes.
  assign clear_start = (state_q == StIdle) && clear_req;
  assign clearing    = (state_q == StClear) || clear_start;
  assign wr_accept   = wr_en && !clearing;

  // Clear FSM next-state logic.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        // Counter wraps to 0 on the last word; it is unused afterwards.
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == '1) begin
          state_d      = StIdle;
          clear_done_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign wr_drop_d = wr_en && clearing;

  // Read port address unpacking.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_addr_lane[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Read word selection: forced zero while clearing, write-first bypass on collision.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_word[i] = mem[rd_addr_lane[i]];
      if (clearing) begin
        rd_word[i] = '0;
      end else if (wr_accept && (wr_addr == rd_addr_lane[i])) begin
        rd_word[i] = wr_data;
      end
    end
  end

  // Read data/valid next state and halt detection.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    halt_hit   = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (rd_en[i]) begin
        rd_data_d[i*DATA_W +: DATA_W] = rd_word[i];
        halt_hit[i]                   = !clearing && (rd_word[i] == HALT_WORD);
      end
    end
    if (clear_start) begin
      halt_port_d = '0;
    end else begin
      halt_port_d = halt_port_q | halt_hit;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      clear_done_q <= 1'b0;
      wr_drop_q    <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= '0;
      halt_port_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_done_q <= clear_done_d;
      wr_drop_q    <= wr_drop_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      halt_port_q  <= halt_port_d;
    end
  end

  // Storage array: no reset, single write per cycle (clear engine has priority).
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign wr_drop    = wr_drop_q;
  assign clear_busy = (state_q == StClear);
  assign clear_done = clear_done_q;
  assign halt_port  = halt_port_q;
  assign halt       = |halt_port_q;

endmodule

// File: tb/tb_ram_multiport_sync.sv
module tb_ram_multiport_sync;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_valid;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_drop;
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;
  logic              halt;
  logic [NR-1:0]     halt_port;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_multiport_sync #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .NUM_RD    (NR),
    .HALT_WORD (16'hFFFF),
    .INIT_FILE ("")
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_drop    (wr_drop),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .halt       (halt),
    .halt_port  (halt_port)
  );

  typedef struct {
    logic [NR-1:0]    en;
    logic [NR*AW-1:0] ra;   // {lane3, lane2, lane1, lane0}
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [NR-1:0]    ev;
    logic [NR*DW-1:0] ed;   // {lane3, lane2, lane1, lane0}
    logic [NR-1:0]    eh;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en     = '0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clear_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rd_data"},    64'(rd_data),    64'h0);
    check({tag, " rd_valid"},   64'(rd_valid),   64'h0);
    check({tag, " wr_drop"},    64'(wr_drop),    64'h0);
    check({tag, " clear_busy"}, 64'(clear_busy), 64'h0);
    check({tag, " clear_done"}, 64'(clear_done), 64'h0);
    check({tag, " halt"},       64'(halt),       64'h0);
    check({tag, " halt_port"},  64'(halt_port),  64'h0);
  endtask

  // mem[k] = k through the write port.
  task automatic preload();
    for (int k = 0; k < 16; k++) begin
      idle();
      wr_en   = 1'b1;
      wr_addr = AW'(k);
      wr_data = DW'(k);
      tick();
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int done_n;
    logic [NR*DW-1:0] exp_d;

    vecs[0] = '{4'b1111, 16'hF550, 1'b0, 4'h0, 16'h0000,
                4'b1111, 64'h000F_0005_0005_0000, 4'b0000};
    vecs[1] = '{4'b0001, 16'h0003, 1'b1, 4'h3, 16'hBEEF,
                4'b0001, 64'h000F_0005_0005_BEEF, 4'b0000};
    vecs[2] = '{4'b1010, 16'h4030, 1'b0, 4'h0, 16'h0000,
                4'b1010, 64'h0004_0005_BEEF_BEEF, 4'b0000};
    vecs[3] = '{4'b0000, 16'h0000, 1'b1, 4'h9, 16'hFFFF,
                4'b0000, 64'h0004_0005_BEEF_BEEF, 4'b0000};
    vecs[4] = '{4'b0100, 16'h0900, 1'b0, 4'h0, 16'h0000,
                4'b0100, 64'h0004_FFFF_BEEF_BEEF, 4'b0100};
    vecs[5] = '{4'b1111, 16'h4321, 1'b0, 4'h0, 16'h0000,
                4'b1111, 64'h0004_BEEF_0002_0001, 4'b0100};

    // Reset.
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    preload();

    // Table-driven reads, writes, collision and halt.
    for (int v = 0; v < 6; v++) begin
      idle();
      rd_en   = vecs[v].en;
      rd_addr = vecs[v].ra;
      wr_en   = vecs[v].we;
      wr_addr = vecs[v].wa;
      wr_data = vecs[v].wd;
      tick();
      check($sformatf("vec%0d rd_valid", v),  64'(rd_valid),  64'(vecs[v].ev));
      check($sformatf("vec%0d rd_data", v),   64'(rd_data),   64'(vecs[v].ed));
      check($sformatf("vec%0d halt_port", v), 64'(halt_port), 64'(vecs[v].eh));
      check($sformatf("vec%0d halt", v),      64'(halt),      64'(|vecs[v].eh));
    end
    idle();

    // Full clear with a read and a dropped write in flight.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr start busy",      64'(clear_busy), 64'h1);
    check("clr start halt",      64'(halt),       64'h0);
    check("clr start halt_port", 64'(halt_port),  64'h0);
    busy_n = 1;
    done_n = 0;
    for (int j = 1; j <= 20; j++) begin
      idle();
      if (j == 3) begin
        rd_en   = '1;
        rd_addr = 16'hF932;
      end
      if (j == 5) begin
        wr_en   = 1'b1;
        wr_addr = 4'h2;
        wr_data = 16'hDEAD;
      end
      tick();
      if (clear_busy) busy_n++;
      if (clear_done) done_n++;
      if (j == 3) begin
        check("clr read valid", 64'(rd_valid), 64'hF);
        check("clr read data",  64'(rd_data),  64'h0);
        check("clr read halt",  64'(halt),     64'h0);
      end
      if (j == 5) check("clr wr_drop pulse", 64'(wr_drop), 64'h1);
      if (j == 6) check("clr wr_drop end",   64'(wr_drop), 64'h0);
      if (j == 16) begin
        check("clr done at end", 64'(clear_done), 64'h1);
        check("clr busy at end", 64'(clear_busy), 64'h0);
      end
    end
    idle();
    check("clr busy cycles", 64'(busy_n), 64'd16);
    check("clr done pulses", 64'(done_n), 64'd1);

    for (int g = 0; g < 4; g++) begin
      idle();
      rd_en   = '1;
      rd_addr = {AW'(g*4+3), AW'(g*4+2), AW'(g*4+1), AW'(g*4)};
      tick();
      check($sformatf("post clr grp%0d", g), 64'(rd_data), 64'h0);
    end
    idle();

    // Reset in the middle of a clear.
    preload();
    rd_en   = '1;
    rd_addr = 16'h4321;
    tick();
    check("pre abort data", 64'(rd_data), 64'h0004_0003_0002_0001);
    idle();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (7) tick();
    check("abort busy before", 64'(clear_busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      idle();
      rd_en   = '1;
      rd_addr = {AW'(g*4+3), AW'(g*4+2), AW'(g*4+1), AW'(g*4)};
      for (int l = 0; l < 4; l++) begin
        exp_d[l*DW +: DW] = (g*4 + l < 7) ? 16'h0 : DW'(g*4 + l);
      end
      tick();
      check($sformatf("abort grp%0d", g), 64'(rd_data), 64'(exp_d));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
